// File: rtl/i2c_target_regs_if.sv
// Bus bundle between an I2C target register block and its surroundings:
// open-drain line levels and enables plus the exported register file.
interface i2c_target_regs_if #(
  parameter int NREGS = 4
);
  localparam int PW = $clog2(NREGS);

  logic                 i2c_sda_in;
  logic                 i2c_scl_in;
  logic                 i2c_sda_oe;
  logic                 i2c_scl_oe;
  logic [NREGS*8-1:0]   regs_out;
  logic                 wr_strobe;
  logic [PW-1:0]        wr_index;
  logic                 busy;

  modport slave (
    input  i2c_sda_in, i2c_scl_in,
    output i2c_sda_oe, i2c_scl_oe, regs_out, wr_strobe, wr_index, busy
  );

  modport master (
    output i2c_sda_in, i2c_scl_in,
    input  i2c_sda_oe, i2c_scl_oe, regs_out, wr_strobe, wr_index, busy
  );
endinterface

// File: rtl/i2c_target_regs.sv
// I2C target exposing NREGS 8-bit registers through a register-pointer protocol.
// Lines are synchronized and glitch-filtered; the target only moves SDA after SCL falls.
module i2c_target_regs #(
  parameter logic [6:0] DEV_ADDR   = 7'h42,
  parameter int         NREGS      = 4,
  parameter int         FILTER_LEN = 3
) (
  input  logic               clk_clk,
  input  logic               reset_reset,
  i2c_target_regs_if.slave   bus
);
  localparam int PW = $clog2(NREGS);
  localparam int FW = $clog2(FILTER_LEN + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_IGNORE
  } state_t;

  // Bit 0 carries SDA, bit 1 carries SCL through identical input pipelines.
  logic [1:0] w_line_in;
  logic [1:0] w_filt;
  logic [1:0] w_prev;
  assign w_line_in = {bus.i2c_scl_in, bus.i2c_sda_in};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_filt
      logic          r_meta;
      logic          r_sync;
      logic          r_filt;
      logic          r_prev;
      logic [FW-1:0] r_cnt;

      always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
          r_meta <= 1'b1;
          r_sync <= 1'b1;
          r_filt <= 1'b1;
          r_prev <= 1'b1;
          r_cnt  <= '0;
        end else begin
          r_meta <= w_line_in[gi];
          r_sync <= r_meta;
          r_prev <= r_filt;
          if (r_sync == r_filt) begin
            r_cnt <= '0;
          end else if (r_cnt == FW'(FILTER_LEN - 1)) begin
            r_filt <= r_sync;
            r_cnt  <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end

      assign w_filt[gi] = r_filt;
      assign w_prev[gi] = r_prev;
    end
  endgenerate

  logic w_sda;
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;
  assign w_sda      = w_filt[0];
  assign w_scl_rise =  w_filt[1] & ~w_prev[1];
  assign w_scl_fall = ~w_filt[1] &  w_prev[1];
  assign w_start    =  w_prev[0] & ~w_filt[0] & w_filt[1] & w_prev[1];
  assign w_stop     = ~w_prev[0] &  w_filt[0] & w_filt[1] & w_prev[1];

  state_t        r_state;
  logic [3:0]    r_bitcnt;
  logic [7:0]    r_shift;
  logic          r_rw;
  logic [PW-1:0] r_ptr;
  logic          r_sda_oe;
  logic          r_busy;
  logic          r_wr_strobe;
  logic [PW-1:0] r_wr_index;
  logic [7:0]    r_regs [NREGS];

  logic [7:0] w_byte;
  assign w_byte = {r_shift[6:0], w_sda};

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_state     <= S_IDLE;
      r_bitcnt    <= '0;
      r_shift     <= '0;
      r_rw        <= 1'b0;
      r_ptr       <= '0;
      r_sda_oe    <= 1'b0;
      r_busy      <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_index  <= '0;
      for (int k = 0; k < NREGS; k++) r_regs[k] <= '0;
    end else begin
      r_wr_strobe <= 1'b0;
      if (w_stop) begin
        r_state  <= S_IDLE;
        r_sda_oe <= 1'b0;
        r_busy   <= 1'b0;
        r_bitcnt <= '0;
      end else if (w_start) begin
        r_state  <= S_ADDR;
        r_sda_oe <= 1'b0;
        r_bitcnt <= '0;
      end else begin
        case (r_state)
          S_ADDR: begin
            if (w_scl_rise) begin
              r_shift  <= w_byte;
              r_bitcnt <= r_bitcnt + 1'b1;
            end else if (w_scl_fall && r_bitcnt == 4'd8) begin
              if (r_shift[7:1] == DEV_ADDR) begin
                r_sda_oe <= 1'b1;
                r_busy   <= 1'b1;
                r_rw     <= r_shift[0];
                r_state  <= S_ADDR_ACK;
              end else begin
                r_state <= S_IGNORE;
              end
            end
          end
          S_ADDR_ACK: begin
            if (w_scl_fall) begin
              r_bitcnt <= '0;
              if (r_rw) begin
                r_shift  <= r_regs[r_ptr];
                r_sda_oe <= ~r_regs[r_ptr][7];
                r_ptr    <= r_ptr + 1'b1;
                r_state  <= S_RDATA;
              end else begin
                r_sda_oe <= 1'b0;
                r_state  <= S_PTR;
              end
            end
          end
          S_PTR: begin
            if (w_scl_rise) begin
              r_shift  <= w_byte;
              r_bitcnt <= r_bitcnt + 1'b1;
            end else if (w_scl_fall && r_bitcnt == 4'd8) begin
              r_ptr    <= r_shift[PW-1:0];
              r_sda_oe <= 1'b1;
              r_state  <= S_PTR_ACK;
            end
          end
          S_PTR_ACK, S_WDATA_ACK: begin
            if (w_scl_fall) begin
              r_sda_oe <= 1'b0;
              r_bitcnt <= '0;
              r_state  <= S_WDATA;
            end
          end
          S_WDATA: begin
            // Commit on the 8th rise so a START/STOP earlier in the byte leaves regs and ptr alone.
            if (w_scl_rise) begin
              r_shift  <= w_byte;
              r_bitcnt <= r_bitcnt + 1'b1;
              if (r_bitcnt == 4'd7) begin
                r_regs[r_ptr] <= w_byte;
                r_wr_strobe   <= 1'b1;
                r_wr_index    <= r_ptr;
                r_ptr         <= r_ptr + 1'b1;
              end
            end else if (w_scl_fall && r_bitcnt == 4'd8) begin
              r_sda_oe <= 1'b1;
              r_state  <= S_WDATA_ACK;
            end
          end
          S_RDATA: begin
            if (w_scl_fall) begin
              if (r_bitcnt == 4'd7) begin
                r_sda_oe <= 1'b0;
                r_state  <= S_RDATA_ACK;
              end else begin
                r_shift  <= {r_shift[6:0], 1'b0};
                r_sda_oe <= ~r_shift[6];
                r_bitcnt <= r_bitcnt + 1'b1;
              end
            end
          end
          S_RDATA_ACK: begin
            // A NACK leaves this state on the rise, so any fall seen here follows an ACK.
            if (w_scl_rise && w_sda) begin
              r_state <= S_IGNORE;
            end else if (w_scl_fall) begin
              r_shift  <= r_regs[r_ptr];
              r_sda_oe <= ~r_regs[r_ptr][7];
              r_ptr    <= r_ptr + 1'b1;
              r_bitcnt <= '0;
              r_state  <= S_RDATA;
            end
          end
          S_IDLE, S_IGNORE: ;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  logic [NREGS*8-1:0] w_regs_flat;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_flat
      assign w_regs_flat[gi*8 +: 8] = r_regs[gi];
    end
  endgenerate

  assign bus.i2c_sda_oe = r_sda_oe;
  assign bus.i2c_scl_oe = 1'b0;
  assign bus.regs_out   = w_regs_flat;
  assign bus.wr_strobe  = r_wr_strobe;
  assign bus.wr_index   = r_wr_index;
  assign bus.busy       = r_busy;
endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: a bit-banged open-drain master drives
// table-driven register writes plus hand-written read, wrap, abort, glitch and reset sequences.
module tb_i2c_target_regs;
  localparam int Q = 10;
  localparam int H = 20;

  logic clk;
  logic rst;
  logic m_sda;
  logic m_scl;

  i2c_target_regs_if #(.NREGS(4)) bus ();

  assign bus.i2c_sda_in = m_sda & ~bus.i2c_sda_oe;
  assign bus.i2c_scl_in = m_scl & ~bus.i2c_scl_oe;

  i2c_target_regs #(
    .DEV_ADDR   (7'h42),
    .NREGS      (4),
    .FILTER_LEN (3)
  ) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int wq[$];
  logic [7:0] m_regs [4];

  always @(negedge clk) if (bus.wr_strobe) wq.push_back(int'(bus.wr_index));

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench did not finish");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    wclk(Q); m_sda = 1'b1;
    wclk(Q); m_scl = 1'b1;
    wclk(H); m_sda = 1'b0;
    wclk(H); m_scl = 1'b0;
  endtask

  task automatic i2c_stop();
    wclk(Q); m_sda = 1'b0;
    wclk(Q); m_scl = 1'b1;
    wclk(H); m_sda = 1'b1;
    wclk(H);
  endtask

  task automatic send_bit(input logic b);
    wclk(Q); m_sda = b;
    wclk(Q); m_scl = 1'b1;
    wclk(H); m_scl = 1'b0;
  endtask

  task automatic recv_bit(output logic b);
    wclk(Q); m_sda = 1'b1;
    wclk(Q); m_scl = 1'b1;
    wclk(Q); b = bus.i2c_sda_in;
    wclk(Q); m_scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(~ack);
  endtask

  function automatic logic [7:0] rg(input int i);
    return bus.regs_out[8*i +: 8];
  endfunction

  function automatic logic [31:0] mpack();
    return {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
  endfunction

  typedef struct {
    logic [7:0] ptr_b;
    logic [7:0] data;
    int         exp_idx;
    logic [7:0] exp_val;
  } wvec_t;

  wvec_t vecs [4];

  initial begin
    logic a0, a1, a2, a3;
    logic [7:0] d0, d1;

    vecs[0] = '{8'h00, 8'h5A, 0, 8'h5A};
    vecs[1] = '{8'h07, 8'hC3, 3, 8'hC3};
    vecs[2] = '{8'hFD, 8'h3C, 1, 8'h3C};
    vecs[3] = '{8'h12, 8'h81, 2, 8'h81};
    for (int k = 0; k < 4; k++) m_regs[k] = 8'h00;

    rst = 1'b1; m_sda = 1'b1; m_scl = 1'b1;
    wclk(5);
    check("rst_sda_oe", 32'(bus.i2c_sda_oe), 32'd0);
    check("rst_scl_oe", 32'(bus.i2c_scl_oe), 32'd0);
    check("rst_regs", bus.regs_out, 32'd0);
    check("rst_strobe", 32'(bus.wr_strobe), 32'd0);
    check("rst_windex", 32'(bus.wr_index), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    wclk(20);

    // Table-driven single-register writes, including ptr bytes with high bits set.
    for (int i = 0; i < 4; i++) begin
      wq.delete();
      i2c_start();
      write_byte(8'h84, a0);
      write_byte(vecs[i].ptr_b, a1);
      write_byte(vecs[i].data, a2);
      i2c_stop();
      m_regs[vecs[i].exp_idx] = vecs[i].exp_val;
      $display("vec %0d: ptr=%02h data=%02h acks=%b%b%b reg[%0d]=%02h", i, vecs[i].ptr_b,
               vecs[i].data, a0, a1, a2, vecs[i].exp_idx, rg(vecs[i].exp_idx));
      check("vec_acks", 32'({a0, a1, a2}), 32'b111);
      check("vec_regs", bus.regs_out, mpack());
      check("vec_strobes", 32'(wq.size()), 32'd1);
      check("vec_windex", (wq.size() > 0) ? 32'(wq[0]) : 32'hFFFF, 32'(vecs[i].exp_idx));
      check("vec_busy_after_stop", 32'(bus.busy), 32'd0);
    end

    // T1: two-byte write with pointer auto-increment.
    wq.delete();
    i2c_start();
    write_byte(8'h84, a0);
    check("t1_busy", 32'(bus.busy), 32'd1);
    write_byte(8'h01, a1);
    write_byte(8'hAA, a2);
    write_byte(8'hBB, a3);
    i2c_stop();
    m_regs[1] = 8'hAA; m_regs[2] = 8'hBB;
    $display("t1 write: acks=%b%b%b%b strobes=%0d", a0, a1, a2, a3, wq.size());
    check("t1_acks", 32'({a0, a1, a2, a3}), 32'b1111);
    check("t1_regs", bus.regs_out, mpack());
    check("t1_strobes", 32'(wq.size()), 32'd2);
    check("t1_widx0", (wq.size() > 0) ? 32'(wq[0]) : 32'hFFFF, 32'd1);
    check("t1_widx1", (wq.size() > 1) ? 32'(wq[1]) : 32'hFFFF, 32'd2);

    // T2: set pointer, repeated START, read two bytes ACK then NACK.
    i2c_start();
    write_byte(8'h84, a0);
    write_byte(8'h01, a1);
    i2c_start();
    write_byte(8'h85, a2);
    read_byte(1'b1, d0);
    read_byte(1'b0, d1);
    wclk(10);
    check("t2_sda_released", 32'(bus.i2c_sda_oe), 32'd0);
    $display("t2 read: acks=%b%b%b data=%02h %02h", a0, a1, a2, d0, d1);
    check("t2_acks", 32'({a0, a1, a2}), 32'b111);
    check("t2_byte0", 32'(d0), 32'hAA);
    check("t2_byte1", 32'(d1), 32'hBB);
    read_byte(1'b0, d0);
    check("t2_after_nack", 32'(d0), 32'hFF);
    i2c_stop();
    check("t2_busy_after_stop", 32'(bus.busy), 32'd0);

    // T3: foreign address is never acknowledged.
    wq.delete();
    i2c_start();
    write_byte(8'h90, a0);
    check("t3_busy", 32'(bus.busy), 32'd0);
    write_byte(8'h55, a1);
    i2c_stop();
    $display("t3 wrong addr: acks=%b%b", a0, a1);
    check("t3_acks", 32'({a0, a1}), 32'b00);
    check("t3_regs", bus.regs_out, mpack());
    check("t3_strobes", 32'(wq.size()), 32'd0);

    // T4: pointer wrap from 3 to 0, then read shows ptr landed on 1.
    wq.delete();
    i2c_start();
    write_byte(8'h84, a0);
    write_byte(8'h03, a1);
    write_byte(8'h11, a2);
    write_byte(8'h22, a3);
    i2c_stop();
    m_regs[3] = 8'h11; m_regs[0] = 8'h22;
    check("t4_acks", 32'({a0, a1, a2, a3}), 32'b1111);
    check("t4_regs", bus.regs_out, mpack());
    check("t4_widx1", (wq.size() > 1) ? 32'(wq[1]) : 32'hFFFF, 32'd0);
    i2c_start();
    write_byte(8'h85, a0);
    read_byte(1'b0, d0);
    i2c_stop();
    $display("t4 wrap: read after wrap=%02h", d0);
    check("t4_ptr_is_1", 32'(d0), 32'(m_regs[1]));

    // Mid-byte STOP aborts the data byte: no write, pointer unchanged.
    wq.delete();
    i2c_start();
    write_byte(8'h84, a0);
    write_byte(8'h01, a1);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    i2c_stop();
    check("abort_regs", bus.regs_out, mpack());
    check("abort_strobes", 32'(wq.size()), 32'd0);
    i2c_start();
    write_byte(8'h85, a0);
    read_byte(1'b0, d0);
    i2c_stop();
    $display("abort: read back=%02h", d0);
    check("abort_ptr", 32'(d0), 32'(m_regs[1]));

    // T5: 2-clk SDA dip with SCL high must not register as START.
    wclk(Q);
    m_sda = 1'b0;
    wclk(2);
    m_sda = 1'b1;
    wclk(H);
    check("t5_busy", 32'(bus.busy), 32'd0);
    write_byte(8'h84, a0);
    $display("t5 glitch: ack without start=%b", a0);
    check("t5_no_ack", 32'(a0), 32'd0);
    i2c_stop();

    // T6: reset while the target holds SDA low for a 0 data bit.
    i2c_start();
    write_byte(8'h84, a0);
    write_byte(8'h00, a1);
    i2c_stop();
    i2c_start();
    write_byte(8'h85, a0);
    wclk(10);
    check("t6_driving", 32'(bus.i2c_sda_oe), 32'd1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("t6_sda_async", 32'(bus.i2c_sda_oe), 32'd0);
    check("t6_regs", bus.regs_out, 32'd0);
    for (int k = 0; k < 4; k++) m_regs[k] = 8'h00;
    wclk(3);
    rst = 1'b0;
    wclk(Q);
    m_scl = 1'b1;
    wclk(H);
    i2c_start();
    write_byte(8'h85, a0);
    read_byte(1'b0, d0);
    i2c_stop();
    check("t6_ptr_reset", 32'(d0), 32'd0);
    i2c_start();
    write_byte(8'h84, a0);
    write_byte(8'h02, a1);
    write_byte(8'h77, a2);
    i2c_stop();
    m_regs[2] = 8'h77;
    $display("t6 after reset: acks=%b%b%b regs=%08h", a0, a1, a2, bus.regs_out);
    check("t6_acks", 32'({a0, a1, a2}), 32'b111);
    check("t6_regs_after", bus.regs_out, mpack());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
